wb_cdb_arbiter: RTL

- Shares the single PRF write port / common data bus (CDB) between N_SRC completing FUs: ALU, branch, mem.
- Each source gets a DEPTH-entry skid FIFO. Non-empty heads are granted round-robin onto one registered CDB beat.
- The CDB drives the phys_reg_file ALU write port, ROB completion and RS wakeup.
- Results younger than a mispredicted branch are squashed.

---
 rtl/types_pkg.sv | 32 +++
 rtl/wb_skid_fifo.sv | 102 ++++++++++
 rtl/wb_cdb_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared types for the writeback / common data bus path: CDB beat layout,
// source index constants and the ROB age comparison used for flush squashing.
package types_pkg;

  localparam int CDB_PD_W   = 7;
  localparam int CDB_ROB_W  = 5;
  localparam int CDB_DATA_W = 32;

  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_B   = 1;
  localparam int CDB_SRC_MEM = 2;

  typedef struct packed {
    logic                  valid;
    logic [CDB_PD_W-1:0]   pd;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_ROB_W-1:0]  rob;
  } cdb_data_t;

  // Ages are measured as distance past the mispredicted branch in the circular
  // ROB; anything strictly between the branch and the allocation tail is younger.
  function automatic logic rob_younger(input logic [CDB_ROB_W-1:0] tag,
                                       input logic [CDB_ROB_W-1:0] mis_tag,
                                       input logic [CDB_ROB_W-1:0] tail);
    logic [CDB_ROB_W-1:0] d_tag;
    logic [CDB_ROB_W-1:0] d_tail;
    d_tag  = tag - mis_tag;
    d_tail = tail - mis_tag;
    return (d_tag != '0) && (d_tag < d_tail);
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Per-source skid FIFO for the CDB arbiter. Holds completed results until they
// win the bus, and carries a kill bit per entry so a mispredict can squash
// queued results that are younger than the branch.
module wb_skid_fifo
  import types_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int PD_W   = CDB_PD_W,
  parameter int DATA_W = CDB_DATA_W,
  parameter int ROB_W  = CDB_ROB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [PD_W-1:0]   i_pd,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ROB_W-1:0]  i_rob,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [ROB_W-1:0]  i_mis_tag,
  input  logic [ROB_W-1:0]  i_tail,
  output logic              o_ready,
  output logic              o_nonempty,
  output logic              o_kill,
  output logic [PD_W-1:0]   o_pd,
  output logic [DATA_W-1:0] o_data,
  output logic [ROB_W-1:0]  o_rob
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PD_W-1:0]   r_pd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ROB_W-1:0]  r_rob  [DEPTH];
  logic [DEPTH-1:0]  r_kill;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;

  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic [DEPTH-1:0]  w_slot_young;

  // Ready depends only on the registered count, so a full FIFO popped this
  // cycle still refuses the incoming beat.
  assign o_ready    = (r_count < (PTR_W+1)'(DEPTH));
  assign o_nonempty = (r_count != '0);
  assign o_kill     = r_kill[r_rd_ptr];
  assign o_pd       = r_pd[r_rd_ptr];
  assign o_data     = r_data[r_rd_ptr];
  assign o_rob      = r_rob[r_rd_ptr];

  // A younger beat arriving during a mispredict completes its handshake but is
  // never stored.
  assign w_drop = i_flush && rob_younger(i_rob, i_mis_tag, i_tail);
  assign w_push = i_valid && o_ready && !w_drop;
  assign w_pop  = i_pop && o_nonempty;

  // Per-slot age test against the mispredicted branch.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    w_slot_young = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_slot_young[j] = rob_younger(r_rob[j], i_mis_tag, i_tail);
    end
  end

  // Pointers, occupancy and kill bits; these define what is queued and so are reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_kill   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      for (int j = 0; j < DEPTH; j++) begin
        r_kill[j] <= r_kill[j] | (i_flush && w_slot_young[j]);
      end
      if (w_push) begin
        r_kill[r_wr_ptr] <= 1'b0;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // Entry payload storage, written on push.
  // NOTE: payload storage has no reset; the count and kill bits decide what is meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pd[r_wr_ptr]   <= i_pd;
      r_data[r_wr_ptr] <= i_data;
      r_rob[r_wr_ptr]  <= i_rob;
    end
  end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter: N_SRC completing FUs share one registered CDB beat, which
// is also the PRF write port. Each source feeds a skid FIFO; live heads are
// granted round-robin, killed heads drain silently without using the grant.
// Optional build macro CDB_PERF_CNT_EN adds saturating beat/conflict counters.
module wb_cdb_arbiter
  import types_pkg::*;
#(
  parameter int N_SRC  = 3,
  parameter int DEPTH  = 2,
  parameter int PD_W   = CDB_PD_W,
  parameter int ROB_W  = CDB_ROB_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC*PD_W-1:0]    src_pd,
  input  logic [N_SRC*DATA_W-1:0]  src_data,
  input  logic [N_SRC*ROB_W-1:0]   src_rob,
  output logic [N_SRC-1:0]         src_ready,
  input  logic [ROB_W-1:0]         curr_rob_tag,
  input  logic                     mispredict,
  input  logic [ROB_W-1:0]         mispredict_tag,
  output logic                     cdb_valid,
  output logic [PD_W-1:0]          cdb_pd,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [ROB_W-1:0]         cdb_rob,
  output logic [$clog2(N_SRC)-1:0] cdb_src
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_beats,
  output logic [31:0]              perf_conflicts
`endif
);

  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]  w_nonempty;
  logic [N_SRC-1:0]  w_kill;
  logic [N_SRC-1:0]  w_live;
  logic [N_SRC-1:0]  w_grant;
  logic [N_SRC-1:0]  w_pop;
  logic [PD_W-1:0]   w_head_pd   [N_SRC];
  logic [DATA_W-1:0] w_head_data [N_SRC];
  logic [ROB_W-1:0]  w_head_rob  [N_SRC];
  logic              w_found;
  logic [SRC_W-1:0]  w_win;
  logic              w_win_young;
  int                w_idx;
  logic [SRC_W-1:0]  r_rr;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    wb_skid_fifo #(
      .DEPTH  (DEPTH),
      .PD_W   (PD_W),
      .DATA_W (DATA_W),
      .ROB_W  (ROB_W)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_valid    (src_valid[i]),
      .i_pd       (src_pd[i*PD_W +: PD_W]),
      .i_data     (src_data[i*DATA_W +: DATA_W]),
      .i_rob      (src_rob[i*ROB_W +: ROB_W]),
      .i_pop      (w_pop[i]),
      .i_flush    (mispredict),
      .i_mis_tag  (mispredict_tag),
      .i_tail     (curr_rob_tag),
      .o_ready    (src_ready[i]),
      .o_nonempty (w_nonempty[i]),
      .o_kill     (w_kill[i]),
      .o_pd       (w_head_pd[i]),
      .o_data     (w_head_data[i]),
      .o_rob      (w_head_rob[i])
    );
  end

  assign w_live = w_nonempty & ~w_kill;

  // Round-robin pick of the first live head at or after the rr pointer; killed
  // heads are popped alongside without affecting the pick.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    w_grant = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_idx = (int'(r_rr) + k) % N_SRC;
      if (!w_found && w_live[w_idx]) begin
        w_found = 1'b1;
        w_win   = SRC_W'(w_idx);
      end
    end
    if (w_found) begin
      w_grant[w_win] = 1'b1;
    end
    w_pop = w_grant | (w_nonempty & w_kill);
  end

  // A winner selected in the mispredict cycle is dropped if it is younger.
  assign w_win_young = mispredict &&
                       rob_younger(w_head_rob[w_win], mispredict_tag, curr_rob_tag);

  // CDB beat register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr      <= '0;
      cdb_valid <= 1'b0;
      cdb_pd    <= '0;
      cdb_data  <= '0;
      cdb_rob   <= '0;
      cdb_src   <= '0;
    end else if (w_found) begin
      r_rr <= (w_win == SRC_W'(N_SRC - 1)) ? '0 : w_win + SRC_W'(1);
      if (w_win_young) begin
        cdb_valid <= 1'b0;
      end else begin
        cdb_valid <= 1'b1;
        cdb_pd    <= w_head_pd[w_win];
        cdb_data  <= w_head_data[w_win];
        cdb_rob   <= w_head_rob[w_win];
        cdb_src   <= w_win;
      end
    end else begin
      cdb_valid <= 1'b0;
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic [SRC_W:0] w_n_live;

  // Number of live heads competing this cycle.
  always_comb begin
    w_n_live = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_n_live = w_n_live + (SRC_W+1)'(w_live[i]);
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_beats     <= '0;
      perf_conflicts <= '0;
    end else begin
      if (cdb_valid && (perf_beats != '1)) begin
        perf_beats <= perf_beats + 32'd1;
      end
      if ((w_n_live >= (SRC_W+1)'(2)) && (perf_conflicts != '1)) begin
        perf_conflicts <= perf_conflicts + 32'd1;
      end
    end
  end
`endif

endmodule
